// File: rtl/ex_stage.sv
// Execute stage: one-hot ALU, 32-cycle restoring divider, data SRAM request issue.
// Forwards control fields, ALU/divider result, store data and pc toward MEM.
module ex_stage #(
    parameter int unsigned ID_BUS_W = 152,
    parameter int unsigned EX_BUS_W = 104
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                id_to_ex_valid,
    input  logic [ID_BUS_W-1:0] id_reg,
    output logic                ex_allowin,
    input  logic                mem_allowin,
    output logic                ex_to_mem_valid,
    output logic [EX_BUS_W-1:0] ex_reg,
    output logic                data_sram_en,
    output logic [3:0]          data_sram_we,
    output logic [31:0]         data_sram_addr,
    output logic [31:0]         data_sram_wdata
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_t;

    logic                ex_valid;
    logic                ex_ready_go;
    logic [ID_BUS_W-1:0] id_q;

    logic [11:0]     alu_op;
    logic [3:0]      div_op;
    logic            res_from_mem;
    logic            mem_we;
    logic            gr_we;
    logic [4:0]      dest;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] rkd_value;
    logic [XLEN-1:0] pc;

    assign {alu_op, div_op, res_from_mem, mem_we, gr_we, dest,
            src1, src2, rkd_value, pc} = id_q;

    // Pipeline handshake and payload latch
    assign ex_allowin      = !ex_valid || (ex_ready_go && mem_allowin);
    assign ex_to_mem_valid = ex_valid && ex_ready_go;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ex_valid <= 1'b0;
            id_q     <= '0;
        end else if (ex_allowin) begin
            ex_valid <= id_to_ex_valid;
            if (id_to_ex_valid) begin
                id_q <= id_reg;
            end
        end
    end

    // ALU: AND-OR mux over one-hot selects
    logic [XLEN-1:0] add_res;
    logic [XLEN-1:0] sub_res;
    logic [XLEN-1:0] alu_res;
    logic [4:0]      sa;

    assign sa      = src2[4:0];
    assign add_res = src1 + src2;
    assign sub_res = src1 - src2;

    always_comb begin
        alu_res = ({XLEN{alu_op[0]}}  & add_res)
                | ({XLEN{alu_op[1]}}  & sub_res)
                | ({XLEN{alu_op[2]}}  & XLEN'($signed(src1) < $signed(src2)))
                | ({XLEN{alu_op[3]}}  & XLEN'(src1 < src2))
                | ({XLEN{alu_op[4]}}  & (src1 & src2))
                | ({XLEN{alu_op[5]}}  & ~(src1 | src2))
                | ({XLEN{alu_op[6]}}  & (src1 | src2))
                | ({XLEN{alu_op[7]}}  & (src1 ^ src2))
                | ({XLEN{alu_op[8]}}  & (src1 << sa))
                | ({XLEN{alu_op[9]}}  & (src1 >> sa))
                | ({XLEN{alu_op[10]}} & XLEN'($signed(src1) >>> sa))
                | ({XLEN{alu_op[11]}} & src2);
    end

    // Divider operands: magnitudes for signed ops, sign fixups applied at the output
    logic            div_active;
    logic            div_signed;
    logic            dividend_neg;
    logic            divisor_neg;
    logic [XLEN-1:0] dividend_abs;
    logic [XLEN-1:0] divisor_abs;

    assign div_active   = |div_op;
    assign div_signed   = div_op[0] | div_op[1];
    assign dividend_neg = div_signed && src1[XLEN-1];
    assign divisor_neg  = div_signed && src2[XLEN-1];
    assign dividend_abs = dividend_neg ? (~src1 + 1'b1) : src1;
    assign divisor_abs  = divisor_neg  ? (~src2 + 1'b1) : src2;

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN:0]    shifted;

    assign shifted = {rem_q, quo_q[XLEN-1]};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
        end
    end

    // Divider next state: one restoring step per BUSY cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        case (state_q)
            S_IDLE: begin
                if (ex_valid && div_active) begin
                    state_d = S_BUSY;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = dividend_abs;
                end
            end
            S_BUSY: begin
                if (shifted >= {1'b0, divisor_abs}) begin
                    rem_d = XLEN'(shifted - {1'b0, divisor_abs});
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = shifted[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ex_to_mem_valid && mem_allowin) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] div_res;
    logic [XLEN-1:0] alu_result;

    // Zero divisor forces an all-ones quotient regardless of signs
    assign quo_fix    = (src2 == '0) ? '1
                      : ((dividend_neg ^ divisor_neg) ? (~quo_q + 1'b1) : quo_q);
    assign rem_fix    = dividend_neg ? (~rem_q + 1'b1) : rem_q;
    assign div_res    = (div_op[0] | div_op[2]) ? quo_fix : rem_fix;
    assign alu_result = div_active ? div_res : alu_res;

    assign ex_ready_go = !div_active || (state_q == S_DONE);

    assign ex_reg = {res_from_mem, mem_we, gr_we, dest, alu_result, rkd_value, pc};

    // One SRAM request, issued on the handshake cycle
    assign data_sram_en    = ex_valid && ex_ready_go && mem_allowin && (res_from_mem || mem_we);
    assign data_sram_we    = {4{mem_we && data_sram_en}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = rkd_value;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vectors, scoreboard queue of expected ex_reg values
// popped by a monitor on each EX->MEM handshake, plus directed timing checks.
module tb_ex_stage;

    logic         clk;
    logic         resetn;
    logic         id_to_ex_valid;
    logic [151:0] id_reg;
    logic         ex_allowin;
    logic         mem_allowin;
    logic         ex_to_mem_valid;
    logic [103:0] ex_reg;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    ex_stage dut (
        .clk            (clk),
        .resetn         (resetn),
        .id_to_ex_valid (id_to_ex_valid),
        .id_reg         (id_reg),
        .ex_allowin     (ex_allowin),
        .mem_allowin    (mem_allowin),
        .ex_to_mem_valid(ex_to_mem_valid),
        .ex_reg         (ex_reg),
        .data_sram_en   (data_sram_en),
        .data_sram_we   (data_sram_we),
        .data_sram_addr (data_sram_addr),
        .data_sram_wdata(data_sram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [103:0] exp_q[$];

    localparam logic [31:0] PC0 = 32'h1c00_0040;

    task automatic chk(input string nm, input logic [103:0] act, input logic [103:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [151:0] mk(input logic [11:0] a, input logic [3:0] d,
                                        input logic rfm, input logic we, input logic gr,
                                        input logic [4:0] ds, input logic [31:0] s1,
                                        input logic [31:0] s2, input logic [31:0] rk);
        return {a, d, rfm, we, gr, ds, s1, s2, rk, PC0};
    endfunction

    function automatic logic [103:0] mkx(input logic rfm, input logic we, input logic gr,
                                         input logic [4:0] ds, input logic [31:0] res,
                                         input logic [31:0] rk);
        return {rfm, we, gr, ds, res, rk, PC0};
    endfunction

    // Monitor: every handshake must match the oldest expected result
    always @(negedge clk) begin
        if (resetn && ex_to_mem_valid && mem_allowin) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", ex_reg, '0);
            end else begin
                chk("ex_reg", ex_reg, exp_q.pop_front());
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that latched p
    task automatic send(input logic [151:0] p);
        int t;
        id_reg = p;
        id_to_ex_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!ex_allowin && t < 100);
        if (!ex_allowin) chk("send_timeout", 104'(ex_allowin), 104'(1));
        @(posedge clk);
        #1;
        id_to_ex_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(ex_allowin && !ex_to_mem_valid) && t < 100);
        if (ex_to_mem_valid) chk("drain_timeout", 104'(ex_to_mem_valid), 104'(0));
        @(posedge clk);
        #1;
    endtask

    // Entered in cycle N: stalled through N+32, valid at N+33
    task automatic div_latency(input string nm);
        for (int k = 0; k <= 32; k++) begin
            @(negedge clk);
            if (k == 0 || k == 32) begin
                chk({nm, "_allowin_busy"}, 104'(ex_allowin), 104'(0));
                chk({nm, "_valid_busy"}, 104'(ex_to_mem_valid), 104'(0));
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk({nm, "_valid_n33"}, 104'(ex_to_mem_valid), 104'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [11:0] op, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [31:0] res);
        exp_q.push_back(mkx(1'b0, 1'b0, 1'b1, 5'd7, res, 32'h0));
        send(mk(op, 4'h0, 1'b0, 1'b0, 1'b1, 5'd7, s1, s2, 32'h0));
    endtask

    task automatic div(input logic [3:0] d, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [31:0] res);
        exp_q.push_back(mkx(1'b0, 1'b0, 1'b1, 5'd9, res, 32'h0));
        send(mk(12'h0, d, 1'b0, 1'b0, 1'b1, 5'd9, s1, s2, 32'h0));
    endtask

    initial begin
        resetn = 1'b0;
        id_to_ex_valid = 1'b0;
        id_reg = '0;
        mem_allowin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_valid", 104'(ex_to_mem_valid), 104'(0));
        chk("rst_allowin", 104'(ex_allowin), 104'(1));
        chk("rst_sram_en", 104'(data_sram_en), 104'(0));
        chk("rst_sram_we", 104'(data_sram_we), 104'(0));
        @(posedge clk);
        #1;

        // ADD with zero-cycle latency
        exp_q.push_back(mkx(1'b0, 1'b0, 1'b1, 5'd3, 32'd12, 32'h0));
        send(mk(12'h001, 4'h0, 1'b0, 1'b0, 1'b1, 5'd3, 32'd5, 32'd7, 32'h0));
        @(negedge clk);
        chk("add_valid", 104'(ex_to_mem_valid), 104'(1));
        chk("add_result", 104'(ex_reg[95:64]), 104'(12));
        chk("add_dest", 104'(ex_reg[100:96]), 104'(3));
        drain();

        // Load held by MEM backpressure, then one request
        mem_allowin = 1'b0;
        exp_q.push_back(mkx(1'b1, 1'b0, 1'b1, 5'd5, 32'h1004, 32'h0));
        send(mk(12'h001, 4'h0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h1000, 32'd4, 32'h0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ld_hold_en", 104'(data_sram_en), 104'(0));
            chk("ld_hold_allowin", 104'(ex_allowin), 104'(0));
            chk("ld_hold_valid", 104'(ex_to_mem_valid), 104'(1));
            @(posedge clk);
            #1;
        end
        mem_allowin = 1'b1;
        @(negedge clk);
        chk("ld_en", 104'(data_sram_en), 104'(1));
        chk("ld_we", 104'(data_sram_we), 104'(0));
        chk("ld_addr", 104'(data_sram_addr), 104'(32'h1004));
        @(negedge clk);
        chk("ld_en_once", 104'(data_sram_en), 104'(0));
        @(posedge clk);
        #1;

        // Store
        exp_q.push_back(mkx(1'b0, 1'b1, 1'b0, 5'd0, 32'h2008, 32'hdeadbeef));
        send(mk(12'h001, 4'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h2000, 32'd8, 32'hdeadbeef));
        @(negedge clk);
        chk("st_en", 104'(data_sram_en), 104'(1));
        chk("st_we", 104'(data_sram_we), 104'(4'hf));
        chk("st_addr", 104'(data_sram_addr), 104'(32'h2008));
        chk("st_wdata", 104'(data_sram_wdata), 104'(32'hdeadbeef));
        @(posedge clk);
        #1;

        // ALU ops, back to back
        alu(12'h002, 32'd5,          32'd7,          32'hffff_fffe);
        alu(12'h004, 32'hffff_ffff,  32'd1,          32'd1);
        alu(12'h008, 32'hffff_ffff,  32'd1,          32'd0);
        alu(12'h010, 32'h0000_f0f0,  32'h0000_ff00,  32'h0000_f000);
        alu(12'h020, 32'h0,          32'h0,          32'hffff_ffff);
        alu(12'h040, 32'h0000_00f0,  32'h0000_000f,  32'h0000_00ff);
        alu(12'h080, 32'h0000_00ff,  32'h0000_000f,  32'h0000_00f0);
        alu(12'h100, 32'd1,          32'h24,         32'h10);
        alu(12'h200, 32'h8000_0000,  32'd31,         32'd1);
        alu(12'h400, 32'h8000_0000,  32'd4,          32'hf800_0000);
        alu(12'h800, 32'h1111_1111,  32'h1234_5000,  32'h1234_5000);
        alu(12'h001, 32'hffff_ffff,  32'd1,          32'd0);
        alu(12'h050, 32'h0000_00f0,  32'h0000_003c,  32'h0000_00fc);
        alu(12'h000, 32'h1234_5678,  32'h9abc_def0,  32'd0);
        drain();

        // Divides
        div(4'h1, 32'hffff_fff9, 32'd2, 32'hffff_fffd);
        div_latency("divw");
        div(4'h2, 32'hffff_fff9, 32'd2, 32'hffff_ffff);
        div(4'h1, 32'd7, 32'hffff_fffe, 32'hffff_fffd);
        div(4'h4, 32'd9, 32'd0, 32'hffff_ffff);
        div(4'h8, 32'd9, 32'd0, 32'd9);
        div(4'h1, 32'hffff_fffb, 32'd0, 32'hffff_ffff);
        div(4'h2, 32'hffff_fffb, 32'd0, 32'hffff_fffb);
        drain();

        // Overflow case held in DONE under backpressure
        mem_allowin = 1'b0;
        div(4'h1, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000);
        begin
            int t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!ex_to_mem_valid && t < 50);
        end
        for (int i = 0; i < 5; i++) begin
            chk("done_hold_valid", 104'(ex_to_mem_valid), 104'(1));
            chk("done_hold_result", 104'(ex_reg[95:64]), 104'(32'h8000_0000));
            @(posedge clk);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        mem_allowin = 1'b1;
        drain();

        // Reset mid-division, then a clean divide
        send(mk(12'h0, 4'h4, 1'b0, 1'b0, 1'b1, 5'd9, 32'd100, 32'd7, 32'h0));
        repeat (11) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("abort_valid", 104'(ex_to_mem_valid), 104'(0));
        chk("abort_allowin", 104'(ex_allowin), 104'(1));
        chk("abort_sram_en", 104'(data_sram_en), 104'(0));
        @(posedge clk);
        #1;
        div(4'h4, 32'd100, 32'd7, 32'd14);
        div_latency("divwu");
        div(4'h8, 32'd100, 32'd7, 32'd2);
        drain();

        chk("scoreboard_empty", 104'(exp_q.size()), 104'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
